// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus.
// Carries the decoded instruction from the decode stage into the EX slot, the
// flush request from later stages, and returns the registered EX-slot contents,
// the load-use stall request and the saturating stall counter.
//   master : decode side (drives the decoded instruction and flush, observes EX)
//   slave  : the ID/EX register itself
interface id_ex_stage_if;
  // decode side
  logic        inValid;
  logic        regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
  logic [1:0]  aluOp;
  logic [31:0] readData1, readData2, signExtImm, pcPlus4;
  logic [4:0]  rs, rt, rd;
  logic        flush;
  // EX side
  logic        stall;
  logic        exValid;
  logic        exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite;
  logic [1:0]  exAluOp;
  logic [31:0] exReadData1, exReadData2, exImm, exPcPlus4;
  logic [4:0]  exRs, exRt, exRd;
  logic [15:0] stallCount;

  modport master (
    output inValid, regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite,
           aluOp, readData1, readData2, signExtImm, pcPlus4, rs, rt, rd, flush,
    input  stall, exValid, exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite,
           exAluSrc, exRegWrite, exAluOp, exReadData1, exReadData2, exImm, exPcPlus4,
           exRs, exRt, exRd, stallCount
  );

  modport slave (
    input  inValid, regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite,
           aluOp, readData1, readData2, signExtImm, pcPlus4, rs, rt, rd, flush,
    output stall, exValid, exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite,
           exAluSrc, exRegWrite, exAluOp, exReadData1, exReadData2, exImm, exPcPlus4,
           exRs, exRt, exRd, stallCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears the whole EX slot and counter
//   bus   : id_ex_stage_if.slave -- decoded instruction in, EX-slot contents,
//           combinational stall and saturating stallCount out
// A load in EX whose destination is needed by the instruction in decode raises
// stall for one cycle; the bubble it inserts clears exValid and drops the stall.
module id_ex_stage (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  // Control bits packed as {regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite}
  logic        ex_valid_q, ex_valid_d;
  logic [6:0]  ex_ctl_q,   ex_ctl_d;
  logic [1:0]  ex_alu_op_q, ex_alu_op_d;
  logic [31:0] ex_rd1_q, ex_rd2_q, ex_imm_q, ex_pc4_q;
  logic [4:0]  ex_rs_q, ex_rt_q, ex_rd_q;
  logic [15:0] stall_count_q, stall_count_d;

  logic        stall;
  logic        bubble;
  logic        rt_used;

  // rt is a source only for R-type operands (aluSrc=0) or as store data.
  assign rt_used = ~bus.aluSrc | bus.memWrite;

  assign stall = ex_valid_q & ex_ctl_q[4] & (ex_rt_q != 5'd0) & bus.inValid &
                 ((ex_rt_q == bus.rs) | ((ex_rt_q == bus.rt) & rt_used));

  assign bubble = bus.flush | stall | ~bus.inValid;

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_ctl_d      = 7'd0;
    ex_alu_op_d   = 2'b00;
    stall_count_d = stall_count_q;
    if (!bubble) begin
      ex_valid_d  = 1'b1;
      ex_ctl_d    = {bus.regDst, bus.branch, bus.memRead, bus.memToReg,
                     bus.memWrite, bus.aluSrc, bus.regWrite};
      ex_alu_op_d = bus.aluOp;
    end
    // A flushed cycle is not counted as a stall; saturate instead of wrapping.
    if (stall && !bus.flush && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctl_q      <= 7'd0;
      ex_alu_op_q   <= 2'b00;
      ex_rd1_q      <= 32'd0;
      ex_rd2_q      <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_pc4_q      <= 32'd0;
      ex_rs_q       <= 5'd0;
      ex_rt_q       <= 5'd0;
      ex_rd_q       <= 5'd0;
      stall_count_q <= 16'd0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctl_q      <= ex_ctl_d;
      ex_alu_op_q   <= ex_alu_op_d;
      // Operands always load; in a bubble they are don't-care.
      ex_rd1_q      <= bus.readData1;
      ex_rd2_q      <= bus.readData2;
      ex_imm_q      <= bus.signExtImm;
      ex_pc4_q      <= bus.pcPlus4;
      ex_rs_q       <= bus.rs;
      ex_rt_q       <= bus.rt;
      ex_rd_q       <= bus.rd;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.exValid     = ex_valid_q;
  assign bus.exRegDst    = ex_ctl_q[6];
  assign bus.exBranch    = ex_ctl_q[5];
  assign bus.exMemRead   = ex_ctl_q[4];
  assign bus.exMemToReg  = ex_ctl_q[3];
  assign bus.exMemWrite  = ex_ctl_q[2];
  assign bus.exAluSrc    = ex_ctl_q[1];
  assign bus.exRegWrite  = ex_ctl_q[0];
  assign bus.exAluOp     = ex_alu_op_q;
  assign bus.exReadData1 = ex_rd1_q;
  assign bus.exReadData2 = ex_rd2_q;
  assign bus.exImm       = ex_imm_q;
  assign bus.exPcPlus4   = ex_pc4_q;
  assign bus.exRs        = ex_rs_q;
  assign bus.exRt        = ex_rt_q;
  assign bus.exRd        = ex_rd_q;
  assign bus.stallCount  = stall_count_q;

endmodule
